cdk_s256x16: RTL and testbench
==============================

// Module: cdk_s256x16
// PURPOSE
//  - Single-port synchronous SRAM macro model: 256 words x 16 bits, one clock, registered read data.
//  - Backing store for the 128x16 RAM wrapper: the wrapper ties ADDRESS[7] to 0, drives CLOCK from its write strobe,
//    and muxes DATA_OUT with DATA_IN in test mode.
//  - Active-low chip enable and active-low write enable. Tying both to 0 gives "write on every clock edge".
// PARAMETERS
//  ADDR_WIDTH  8    address bits
//  DATA_WIDTH  16   word width
//  DEPTH       256  words implemented; must satisfy DEPTH <= 2**ADDR_WIDTH
// PORTS
//  CLOCK       in   1           single clock; all state updates on its rising edge
//  RESET_N     in   1           reset, synchronous, active-low
//  ADDRESS     in   ADDR_WIDTH  word address
//  DATA_IN     in   DATA_WIDTH  write data
//  DATA_OUT    out  DATA_WIDTH  registered read data
//  WR_ENABLE   in   1           active-low write enable (0 = write, 1 = read)
//  ENABLE      in   1           active-low chip enable (0 = access, 1 = idle)
// BEHAVIOUR
//  - Every update happens on the rising edge of CLOCK. There are no combinational paths from inputs to DATA_OUT.
//  - Precedence per edge: RESET_N, then ENABLE, then WR_ENABLE.
//  - RESET_N==0:
//      - DATA_OUT <= 0.
//      - Memory array untouched; no write occurs even if ENABLE==0 and WR_ENABLE==0.
//  - ENABLE==1 (and not in reset): idle. Memory unchanged, DATA_OUT holds its value.
//  - Write (ENABLE==0, WR_ENABLE==0): mem[ADDRESS] <= DATA_IN.
//      - DATA_OUT holds its previous value (see CONFIGURATION for the alternative).
//  - Read (ENABLE==0, WR_ENABLE==1): DATA_OUT <= mem[ADDRESS].
//      - Latency 1 cycle: data is valid after the edge that samples the address.
//  - Back-to-back operations are allowed every cycle, with no wait states.
//      - A read one cycle after a write to the same address returns the new data.
//  - Address range:
//      - If DEPTH < 2**ADDR_WIDTH, addresses >= DEPTH are out of range.
//      - Out-of-range writes are ignored.
//      - Out-of-range reads load DATA_OUT with 0.
//  - Contents never written since power-up are undefined (X in simulation). Reset does not initialise the array.
//  - Input X or Z on ADDRESS during an access: the model performs no write and loads DATA_OUT with X in simulation.
//  - Reset deasserted mid-sequence: the first edge with RESET_N==1 performs a normal access.
// CONFIGURATION
//  - Macro CDK_S256X16_WRITE_THROUGH_EN.
//  - Defined: on a write, DATA_OUT <= DATA_IN on the same edge as the array write (write-through).
//  - Undefined (default): on a write, DATA_OUT holds its prior value.
//  - Read, idle and reset behaviour are identical in both builds.
// TESTING
//  1. Reset: hold RESET_N=0 for 2 edges with ENABLE=0, WR_ENABLE=0, ADDRESS=8'h05, DATA_IN=16'hFFFF.
//     -> DATA_OUT==16'h0000.
//     -> After release, a read of 8'h05 is not 16'hFFFF unless it was written after reset.
//  2. Write/read: write 16'hA5A5 to 8'h00 and 16'h5A5A to 8'hFF, then read 8'h00 and 8'hFF.
//     -> DATA_OUT==16'hA5A5, then 16'h5A5A, each one edge after its address is sampled.
//  3. Chip disable: write 16'h1234 to 8'h10. Then ENABLE=1, WR_ENABLE=0, DATA_IN=16'hDEAD for 3 edges. Then read 8'h10.
//     -> Memory still 16'h1234.
//     -> DATA_OUT unchanged during the idle edges.
//  4. Back-to-back: write 16'h0001 to 8'h7F, then read 8'h7F on the next edge.
//     -> DATA_OUT==16'h0001.
//  5. Write data path: read 8'h20 (16'hBEEF) so DATA_OUT==16'hBEEF, then write 16'hCAFE to 8'h21.
//     -> Default build: DATA_OUT stays 16'hBEEF.
//     -> With CDK_S256X16_WRITE_THROUGH_EN: DATA_OUT==16'hCAFE.
//  6. Full sweep: write mem[i]=i*16'h0101 for i=0..255, then read all 256 addresses.
//     -> Every read matches; no aliasing between address 8'h00 and 8'h80.

Source files
------------

// File: rtl/cdk_s256x16_if.sv
`default_nettype none
// ============================================================================
// Module      : cdk_s256x16_if
// Description : Access bus for the 256x16 single-port SRAM macro model.
//               The master drives the address, write data and active-low
//               strobes. The slave returns registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface cdk_s256x16_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] ADDRESS;
   logic [DATA_WIDTH-1:0] DATA_IN;
   logic [DATA_WIDTH-1:0] DATA_OUT;
   logic                  WR_ENABLE;   // active-low: 0 = write, 1 = read
   logic                  ENABLE;      // active-low: 0 = access, 1 = idle

   modport master (
      output ADDRESS,
      output DATA_IN,
      output WR_ENABLE,
      output ENABLE,
      input  DATA_OUT
   );

   modport slave (
      input  ADDRESS,
      input  DATA_IN,
      input  WR_ENABLE,
      input  ENABLE,
      output DATA_OUT
   );
endinterface
`default_nettype wire

// File: rtl/cdk_s256x16.sv
`default_nettype none
// ============================================================================
// Module      : cdk_s256x16
// Description : Single-port synchronous SRAM model, DEPTH x DATA_WIDTH,
//               one clock, registered read data, active-low chip enable
//               and active-low write enable. Reset clears only DATA_OUT;
//               the array is never initialised.
//               Optional feature macro: CDK_S256X16_WRITE_THROUGH_EN
//               (when defined, a write also loads DATA_OUT with DATA_IN).
// Revision    : 1.0 - initial release
// ============================================================================
module cdk_s256x16 #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 256
) (
   input  wire logic       CLOCK,
   input  wire logic       RESET_N,
   cdk_s256x16_if.slave    bus
);

   localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_data_out;

   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  w_access;
   logic                  w_write;
   logic                  w_in_range;
   logic                  w_addr_known;

   assign w_addr     = bus.ADDRESS;
   assign w_access   = ~bus.ENABLE;
   assign w_write    = w_access & ~bus.WR_ENABLE;
   assign w_in_range = ({1'b0, w_addr} < c_depth);

   // An unknown address must neither corrupt the array nor return clean
   // data in simulation; hardware always sees a known address.
`ifdef SYNTHESIS
   assign w_addr_known = 1'b1;
`else
   assign w_addr_known = ~$isunknown(w_addr);
`endif

   // Array write: only on an enabled, in-range, known-address write outside reset.
   always_ff @(posedge CLOCK) begin
      if (RESET_N && w_write && w_addr_known && w_in_range) begin
         r_mem[w_addr] <= bus.DATA_IN;
      end
   end

   // Output register: reset clears it, reads load it, idle and writes hold it.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         r_data_out <= '0;
      end else if (w_access) begin
         if (!w_addr_known) begin
            r_data_out <= 'x;
         end else if (bus.WR_ENABLE) begin
            r_data_out <= w_in_range ? r_mem[w_addr] : '0;
         end else begin
`ifdef CDK_S256X16_WRITE_THROUGH_EN
            r_data_out <= bus.DATA_IN;
`endif
         end
      end
   end

   assign bus.DATA_OUT = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_cdk_s256x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdk_s256x16
// Description : Directed self-checking bench for the cdk_s256x16 SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdk_s256x16;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic [15:0] m_dout;   // model of DATA_OUT

   cdk_s256x16_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

   cdk_s256x16 #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (16),
      .DEPTH      (256)
   ) u_dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [15:0] d);
      bus.ENABLE    = 1'b0;
      bus.WR_ENABLE = 1'b0;
      bus.ADDRESS   = a;
      bus.DATA_IN   = d;
      tick();
`ifdef CDK_S256X16_WRITE_THROUGH_EN
      m_dout = d;
`endif
   endtask

   task automatic do_read(input logic [7:0] a);
      bus.ENABLE    = 1'b0;
      bus.WR_ENABLE = 1'b1;
      bus.ADDRESS   = a;
      bus.DATA_IN   = 16'h0000;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_dout   = 16'h0000;

      // 1. Reset with a write request pending
      rst_n         = 1'b0;
      bus.ENABLE    = 1'b0;
      bus.WR_ENABLE = 1'b0;
      bus.ADDRESS   = 8'h05;
      bus.DATA_IN   = 16'hFFFF;
      tick();
      tick();
      check("reset_dout", bus.DATA_OUT, 16'h0000);
      rst_n = 1'b1;
      do_read(8'h05);
      check("reset_no_write", {15'd0, (bus.DATA_OUT === 16'hFFFF)}, 16'h0000);

      // 2. Write / read at both ends of the range
      do_write(8'h00, 16'hA5A5);
      do_write(8'hFF, 16'h5A5A);
      do_read(8'h00);
      check("rd_00", bus.DATA_OUT, 16'hA5A5);
      do_read(8'hFF);
      check("rd_ff", bus.DATA_OUT, 16'h5A5A);
      m_dout = 16'h5A5A;

      // 3. Chip disable holds memory and output
      do_write(8'h10, 16'h1234);
      check("wr_10_dout", bus.DATA_OUT, m_dout);
      bus.ENABLE    = 1'b1;
      bus.WR_ENABLE = 1'b0;
      bus.DATA_IN   = 16'hDEAD;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("idle_dout", bus.DATA_OUT, m_dout);
      end
      bus.WR_ENABLE = 1'b1;
      tick();
      check("idle_rd_dout", bus.DATA_OUT, m_dout);
      do_read(8'h10);
      check("rd_10", bus.DATA_OUT, 16'h1234);

      // 4. Back-to-back write then read
      do_write(8'h7F, 16'h0001);
      do_read(8'h7F);
      check("b2b_7f", bus.DATA_OUT, 16'h0001);

      // 5. Output during a write
      do_write(8'h20, 16'hBEEF);
      do_read(8'h20);
      check("rd_20", bus.DATA_OUT, 16'hBEEF);
      m_dout = 16'hBEEF;
      do_write(8'h21, 16'hCAFE);
`ifdef CDK_S256X16_WRITE_THROUGH_EN
      check("wr_dout", bus.DATA_OUT, 16'hCAFE);
`else
      check("wr_dout", bus.DATA_OUT, 16'hBEEF);
`endif
      do_read(8'h21);
      check("rd_21", bus.DATA_OUT, 16'hCAFE);

      // 6. Full sweep: mem[i] = i * 16'h0101
      for (int i = 0; i < 256; i++) begin
         do_write(i[7:0], {i[7:0], i[7:0]});
      end
      for (int i = 0; i < 256; i++) begin
         do_read(i[7:0]);
         check("sweep", bus.DATA_OUT, {i[7:0], i[7:0]});
      end
      do_read(8'h00);
      check("alias_00", bus.DATA_OUT, 16'h0000);
      do_read(8'h80);
      check("alias_80", bus.DATA_OUT, 16'h8080);

      // 7. Reset mid-sequence: no write in reset, first released edge is a normal access
      rst_n         = 1'b0;
      bus.ENABLE    = 1'b0;
      bus.WR_ENABLE = 1'b0;
      bus.ADDRESS   = 8'h30;
      bus.DATA_IN   = 16'h1111;
      tick();
      check("mid_reset_dout", bus.DATA_OUT, 16'h0000);
      rst_n = 1'b1;
      do_read(8'h20);
      check("post_reset_rd", bus.DATA_OUT, 16'h2020);
      do_read(8'h30);
      check("reset_no_write_30", bus.DATA_OUT, 16'h3030);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
